fib_timer_source: RTL and testbench

- Producer stage directly upstream of the clk_1-side write port of the clock-crossing buffer.
- Generates the 16-bit value stream in one of two modes: Fibonacci sequence, or a countdown timer.
- Presents each value as data_1 with a one-cycle data_1_en strobe.
- Obeys buffer_full back-pressure so that no value is lost or duplicated.

---
 rtl/fib_timer_source_pkg.sv | 19 +
 rtl/fib_timer_source_fib_step.sv | 28 ++
 rtl/fib_timer_source.sv | 147 ++++++++++++++
 tb/tb_fib_timer_source.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_timer_source_pkg.sv
// Shared definitions for the Fibonacci/timer producer stage and its consumers.
// Holds the FSM state encoding, mode selectors and the value-range constants.
package fib_timer_source_pkg;

    localparam int DATA_WIDTH    = 16;
    // F24 is the largest Fibonacci term that still fits in 16 bits.
    localparam int FIB_LAST_TERM = 46368;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_TMR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/fib_timer_source_fib_step.sv
// Combinational Fibonacci step: next term from (cur, nxt) plus last-term detect.
// The sum is formed one bit wider so a carry out saturates instead of wrapping.
module fib_timer_source_fib_step
    import fib_timer_source_pkg::*;
#(
    parameter int WIDTH    = DATA_WIDTH,
    parameter int FIB_LAST = FIB_LAST_TERM
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] nxt_i,
    output logic [WIDTH-1:0] next_o,
    output logic             last_o
);

    logic [WIDTH:0] sum_s;

    // Widened add; the saturated value only ever lands in nxt after the last term.
    always_comb begin
        sum_s = {1'b0, cur_i} + {1'b0, nxt_i};
        if (sum_s[WIDTH]) begin
            next_o = {WIDTH{1'b1}};
        end else begin
            next_o = sum_s[WIDTH-1:0];
        end
        last_o = (cur_i == WIDTH'(FIB_LAST));
    end

endmodule

// File: rtl/fib_timer_source.sv
// Producer stage feeding the clk_1 write port of the clock-crossing buffer.
// Emits a Fibonacci or countdown stream, one strobed value per cycle, under back-pressure.
module fib_timer_source
    import fib_timer_source_pkg::*;
#(
    parameter int WIDTH    = DATA_WIDTH,
    parameter int FIB_LAST = FIB_LAST_TERM
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] prog_in,
    input  logic             stop,
    input  logic             buffer_full,
    output logic [WIDTH-1:0] data_1,
    output logic             data_1_en,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] nxt_q, nxt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] fib_next_s;
    logic             fib_last_s;
    logic             is_last_s;

    fib_timer_source_fib_step #(
        .WIDTH    (WIDTH),
        .FIB_LAST (FIB_LAST)
    ) u_fib_step (
        .cur_i  (cur_q),
        .nxt_i  (nxt_q),
        .next_o (fib_next_s),
        .last_o (fib_last_s)
    );

    // Next-state and next-output logic; stop outranks back-pressure, which outranks advance.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        data_d  = data_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        if (mode_q == MODE_FIB) begin
            is_last_s = fib_last_s;
        end else begin
            is_last_s = (cur_q == ZERO_V);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    if (mode == MODE_FIB) begin
                        cur_d = ZERO_V;
                        nxt_d = ONE_V;
                    end else begin
                        cur_d = prog_in;
                        nxt_d = ZERO_V;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (buffer_full) begin
                    state_d = ST_STALL;
                end else begin
                    data_d = cur_q;
                    en_d   = 1'b1;
                    if (is_last_s) begin
                        state_d = ST_FINISH;
                    end else if (mode_q == MODE_FIB) begin
                        cur_d = nxt_q;
                        nxt_d = fib_next_s;
                    end else begin
                        cur_d = cur_q - ONE_V;
                    end
                end
            end
            ST_STALL: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!buffer_full) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_STALL);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FIB;
            cur_q   <= ZERO_V;
            nxt_q   <= ZERO_V;
            data_q  <= ZERO_V;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_1    = data_q;
    assign data_1_en = en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fib_timer_source.sv
// Self-checking bench for fib_timer_source: directed scenarios plus randomized
// back-pressure and timer start values, checked against a sequence-level model.
module tb_fib_timer_source;
    import fib_timer_source_pkg::*;

    logic        clk_1 = 1'b0;
    logic        rst, start, mode, stop, buffer_full;
    logic [15:0] prog_in;
    logic [15:0] data_1;
    logic        data_1_en, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    fib_timer_source dut (
        .clk_1       (clk_1),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .prog_in     (prog_in),
        .stop        (stop),
        .buffer_full (buffer_full),
        .data_1      (data_1),
        .data_1_en   (data_1_en),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk_1 = ~clk_1;

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // Watch n cycles in which no strobe and no done may appear.
    task automatic expect_quiet(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (data_1_en || done || busy) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    // bf_mode: 0 = never full, 1 = random full, 2 = full for 3 cycles after stall_val.
    task automatic run_stream(input string tag, input logic m, input logic [15:0] p,
                              input int bf_mode, input int stall_val, input bit poke_start);
        int expv[$];
        int got[$];
        int a, b, tmp, t, first, last, done_t, stall_left, budget, n;
        bit bp_bad, bf_applied, busy_at_done;

        if (m == MODE_FIB) begin
            a = 0;
            b = 1;
            forever begin
                expv.push_back(a);
                if (a == 46368) break;
                tmp = a + b;
                a = b;
                b = tmp;
            end
        end else begin
            for (int v = int'(p); v >= 0; v--) expv.push_back(v);
        end

        first = -1; last = -1; done_t = -1; stall_left = 0;
        bp_bad = 1'b0; busy_at_done = 1'b1;
        budget = 4 * expv.size() + 40;

        start = 1'b1; mode = m; prog_in = p; buffer_full = 1'b0;
        tick();
        t = 1;
        start = 1'b0;
        mode = 1'($urandom);
        prog_in = 16'($urandom);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (bf_mode == 1) buffer_full = ($urandom_range(0, 3) == 0);

        while (t < budget && done_t < 0) begin
            bf_applied = buffer_full;
            tick();
            t++;
            if (data_1_en) begin
                if (bf_applied) bp_bad = 1'b1;
                got.push_back(int'(data_1));
                if (first < 0) first = t;
                last = t;
            end
            if (done) begin
                done_t = t;
                busy_at_done = busy;
            end
            case (bf_mode)
                1: buffer_full = ($urandom_range(0, 3) == 0);
                2: begin
                    if (data_1_en && int'(data_1) == stall_val) stall_left = 3;
                    buffer_full = (stall_left > 0);
                    if (stall_left > 0) stall_left--;
                end
                default: buffer_full = 1'b0;
            endcase
            if (poke_start && t == 5) begin
                start = 1'b1;
                mode = 1'($urandom);
                prog_in = 16'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
        end
        buffer_full = 1'b0;
        start = 1'b0;

        check({tag, "_count"}, 32'(got.size()), 32'(expv.size()));
        n = (got.size() < expv.size()) ? got.size() : expv.size();
        for (int i = 0; i < n; i++) begin
            if (i == 0 || i == n - 1 || got[i] != expv[i])
                check($sformatf("%s_val%0d", tag, i), 32'(got[i]), 32'(expv[i]));
        end
        if (bf_mode == 0) check({tag, "_first_latency"}, 32'(first), 32'd2);
        check({tag, "_done_after_last"}, 32'(done_t), 32'(last + 1));
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, "_backpressure"}, 32'(bp_bad), 32'd0);
        expect_quiet({tag, "_quiet_after"}, 4);
    endtask

    initial begin
        int seen;
        rst = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0;
        buffer_full = 1'b0; prog_in = 16'd0;
        tick();
        tick();
        check("reset_data", 32'(data_1), 32'd0);
        check("reset_en", 32'(data_1_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();

        run_stream("fib_full", MODE_FIB, 16'd0, 0, 0, 1'b0);
        run_stream("tmr_3", MODE_TMR, 16'd3, 0, 0, 1'b0);
        run_stream("tmr_0", MODE_TMR, 16'd0, 0, 0, 1'b0);
        run_stream("fib_stall5", MODE_FIB, 16'd0, 2, 5, 1'b0);
        run_stream("fib_busy_start", MODE_FIB, 16'd0, 0, 0, 1'b1);
        run_stream("fib_rand_bp", MODE_FIB, 16'd0, 1, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_stream($sformatf("tmr_rand%0d", r), MODE_TMR,
                       16'($urandom_range(1, 150)), 1, 0, 1'b0);

        // stop during a timer run right after the value 7 is emitted
        start = 1'b1; mode = MODE_TMR; prog_in = 16'd10;
        tick();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            tick();
            if (data_1_en && data_1 == 16'd7) seen = 1;
        end
        check("stop_saw_7", 32'(seen), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_en", 32'(data_1_en), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_data_held", 32'(data_1), 32'd7);
        expect_quiet("stop_quiet", 6);
        run_stream("tmr_after_stop", MODE_TMR, 16'd2, 0, 0, 1'b0);

        // reset mid Fibonacci run
        start = 1'b1; mode = MODE_FIB;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_data", 32'(data_1), 32'd0);
        check("midrst_en", 32'(data_1_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        expect_quiet("midrst_quiet", 4);
        run_stream("fib_after_rst", MODE_FIB, 16'd0, 0, 0, 1'b0);

        // stop and start together in IDLE: nothing starts
        stop = 1'b1; start = 1'b1; mode = MODE_TMR; prog_in = 16'd5;
        tick();
        stop = 1'b0; start = 1'b0;
        check("stopstart_busy", 32'(busy), 32'd0);
        expect_quiet("stopstart_quiet", 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
